// File: rtl/muldiv_array_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_array_sched_pkg
// Description : Shared types and constants for the two-requester
//               multiply/divide array scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_array_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Operation encoding on reqN_op
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Response returned for a divide by zero
    localparam logic [7:0] DZ_RESULT = 8'hFF;
    localparam logic [3:0] DZ_REM    = 4'h0;

endpackage
`default_nettype wire

// File: rtl/muldiv_array_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. When both requests are present
//               the grant goes to the requester not served last; after reset
//               requester 0 is favoured.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 1 = requester 1 was served last, so requester 0 wins the next tie
    logic r_last;

    // Remember which requester was served on every accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (update) begin
            r_last <= gnt[1];
        end
    end

    // Single request passes straight through; a tie is broken by r_last
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_last ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_array_sched.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_array_sched
// Description : Schedules multiply/divide operations from two requesters onto
//               a shared combinational array, holding the array inputs for
//               SETTLE_CYCLES cycles before capturing the result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_array_sched
    import muldiv_array_sched_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [7:0]  req0_a,
    input  logic [3:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [7:0]  req1_a,
    input  logic [3:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_result,
    output logic [3:0]  rsp_rem,
    output logic        rsp_dz,
    output logic        busy,
    output logic [10:0] arr_l,
    output logic [3:0]  arr_b,
    output logic        arr_z,
    input  logic [7:0]  arr_mul,
    input  logic [7:0]  arr_quo,
    input  logic [3:0]  arr_rem
);

    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_op;
    logic        r_id;
    logic [7:0]  r_a;
    logic [3:0]  r_b;
    logic [7:0]  r_result;
    logic [3:0]  r_rem;
    logic        r_dz;

    logic [1:0]  w_gnt;
    logic        w_idle;
    logic        w_accept;
    logic        w_acc_id;
    logic        w_acc_op;
    logic [7:0]  w_acc_a;
    logic [3:0]  w_acc_b;
    logic        w_acc_dz;
    logic        w_capture;
    logic        w_drive;
    logic        w_done;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .update (w_accept),
        .gnt    (w_gnt)
    );

    // Grant/accept decode, next-state logic and all output drive
    always_comb begin
        w_next     = r_state;
        w_idle     = (r_state == IDLE) && !rst;
        req0_ready = w_idle && w_gnt[0];
        req1_ready = w_idle && w_gnt[1];
        w_accept   = w_idle && (w_gnt != 2'b00);
        w_acc_id   = w_gnt[1];
        w_acc_op   = w_acc_id ? req1_op : req0_op;
        w_acc_a    = w_acc_id ? req1_a  : req0_a;
        w_acc_b    = w_acc_id ? req1_b  : req0_b;
        w_acc_dz   = (w_acc_op == OP_DIV) && (w_acc_b == 4'h0);
        w_capture  = (r_state == SETTLE) && (r_cnt == 4'd0);

        unique case (r_state)
            IDLE:    if (w_accept)        w_next = w_acc_dz ? DONE : SETTLE;
            SETTLE:  if (r_cnt == 4'd0)   w_next = DONE;
            DONE:    if (rsp_ready)       w_next = IDLE;
            default:                      w_next = IDLE;
        endcase

        // Array inputs are only driven while the operation is settling
        w_drive = (r_state == SETTLE) && !rst;
        arr_l   = 11'd0;
        arr_b   = 4'd0;
        arr_z   = 1'b0;
        if (w_drive) begin
            arr_l = (r_op == OP_DIV) ? {3'b000, r_a} : {7'b0, r_a[3:0]};
            arr_b = r_b;
            arr_z = r_op;
        end

        w_done     = (r_state == DONE) && !rst;
        rsp_valid  = w_done;
        rsp_id     = w_done ? r_id     : 1'b0;
        rsp_result = w_done ? r_result : 8'h00;
        rsp_rem    = w_done ? r_rem    : 4'h0;
        rsp_dz     = w_done ? r_dz     : 1'b0;
        busy       = (r_state != IDLE) && !rst;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Settle down-counter: loaded on accept, counts to zero in SETTLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_settle_load;
        end else if ((r_state == SETTLE) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Latch the accepted operation so the array inputs stay stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= OP_MUL;
            r_id <= 1'b0;
            r_a  <= 8'h00;
            r_b  <= 4'h0;
        end else if (w_accept) begin
            r_op <= w_acc_op;
            r_id <= w_acc_id;
            r_a  <= w_acc_a;
            r_b  <= w_acc_b;
        end
    end

    // Response registers: divide-by-zero shortcut or array capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 8'h00;
            r_rem    <= 4'h0;
            r_dz     <= 1'b0;
        end else if (w_accept && w_acc_dz) begin
            r_result <= DZ_RESULT;
            r_rem    <= DZ_REM;
            r_dz     <= 1'b1;
        end else if (w_capture) begin
            r_result <= (r_op == OP_DIV) ? arr_quo : arr_mul;
            r_rem    <= (r_op == OP_DIV) ? arr_rem : 4'h0;
            r_dz     <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_array_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_array_sched
// Description : Scoreboard bench for muldiv_array_sched with a behavioural
//               array model that corrupts its outputs until inputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_array_sched;

    localparam int SETTLE = 2;
    localparam int N_RAND = 30;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic [3:0] rem;
        logic       dz;
        int         t_acc;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld [2];
    logic        op  [2];
    logic [7:0]  a   [2];
    logic [3:0]  b   [2];
    logic        rdy0, rdy1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_dz, busy;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_rem;
    logic [10:0] arr_l;
    logic [3:0]  arr_b;
    logic        arr_z;
    logic [7:0]  arr_mul, arr_quo;
    logic [3:0]  arr_rem;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    exp_t sbq [$];
    logic seen_ids [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_array_sched #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0]), .req0_ready(rdy0), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
        .req1_valid(vld[1]), .req1_ready(rdy1), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz), .busy(busy),
        .arr_l(arr_l), .arr_b(arr_b), .arr_z(arr_z),
        .arr_mul(arr_mul), .arr_quo(arr_quo), .arr_rem(arr_rem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Shared array model: outputs are inverted until inputs held SETTLE cycles
    logic [15:0] arr_prev = '0;
    int          stable   = 0;
    logic [7:0]  m_true, q_true;
    logic [3:0]  r_true;
    always @(negedge clk) begin
        if ({arr_z, arr_b, arr_l} == arr_prev) stable <= stable + 1;
        else                                   stable <= 1;
        arr_prev <= {arr_z, arr_b, arr_l};
    end
    always_comb begin
        m_true = {4'b0, arr_l[3:0]} * {4'b0, arr_b};
        q_true = 8'hFF;
        r_true = 4'h0;
        if (arr_b != 4'h0) begin
            q_true = arr_l[7:0] / {4'b0, arr_b};
            r_true = 4'(arr_l[7:0] % {4'b0, arr_b});
        end
    end
    assign arr_mul = (stable >= SETTLE) ? m_true : ~m_true;
    assign arr_quo = (stable >= SETTLE) ? q_true : ~q_true;
    assign arr_rem = (stable >= SETTLE) ? r_true : ~r_true;

    // Reference: expected response and latency straight from the arithmetic
    function automatic exp_t model(input logic id, input logic o, input logic [7:0] aa,
                                   input logic [3:0] bb, input int t);
        exp_t e;
        e.id = id; e.t_acc = t; e.dz = 1'b0; e.lat = SETTLE + 1;
        if (o == 1'b0) begin
            e.res = {4'b0, aa[3:0]} * {4'b0, bb};
            e.rem = 4'h0;
        end else if (bb == 4'h0) begin
            e.res = 8'hFF; e.rem = 4'h0; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.res = aa / {4'b0, bb};
            e.rem = 4'(aa % {4'b0, bb});
        end
        return e;
    endfunction

    // Acceptance side: arbitration expectations and scoreboard push
    logic last_id = 1'b1;
    bit   pend    = 1'b0;
    logic acc_id;
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            last_id = 1'b1;
            pend    = 1'b0;
        end else begin
            if (vld[0] || vld[1] || rdy0 || rdy1)
                chk("ready_when_free", 32'(rdy0 | rdy1), 32'(!pend && (vld[0] || vld[1])));
            if (rdy0 || rdy1) begin
                chk("one_ready", 32'(rdy0 & rdy1), 32'd0);
                acc_id = rdy1;
                chk("ready_has_valid", 32'(vld[acc_id]), 32'd1);
                if (vld[0] && vld[1]) chk("rr_grant", 32'(acc_id), 32'(!last_id));
                sbq.push_back(model(acc_id, op[acc_id], a[acc_id], b[acc_id], cyc));
                last_id = acc_id;
                pend    = 1'b1;
            end
            if (rsp_valid && rsp_ready) pend = 1'b0;
        end
    end

    // Response side: pop and compare, then check hold under backpressure
    bit          in_rsp = 1'b0;
    exp_t        cur;
    logic [13:0] held;
    always @(negedge clk) begin
        if (rst) begin
            in_rsp = 1'b0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                if (sbq.size() == 0) begin
                    note_fail("unexpected_rsp");
                end else begin
                    cur = sbq.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(cur.id));
                    chk("rsp_result", 32'(rsp_result), 32'(cur.res));
                    chk("rsp_rem", 32'(rsp_rem), 32'(cur.rem));
                    chk("rsp_dz", 32'(rsp_dz), 32'(cur.dz));
                    chk("latency", 32'(cyc - cur.t_acc), 32'(cur.lat));
                end
                seen_ids.push_back(rsp_id);
                held   = {rsp_id, rsp_dz, rsp_rem, rsp_result};
                in_rsp = 1'b1;
            end else begin
                chk("rsp_hold", 32'({rsp_id, rsp_dz, rsp_rem, rsp_result}), 32'(held));
            end
            chk("busy_in_done", 32'(busy), 32'd1);
            if (rsp_ready) in_rsp = 1'b0;
        end
    end

    // Present one operation and hold it until accepted (entered after posedge)
    task automatic issue(input int id, input logic o, input logic [7:0] aa, input logic [3:0] bb);
        bit got = 1'b0;
        vld[id] = 1'b1; op[id] = o; a[id] = aa; b[id] = bb;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = (id == 0) ? rdy0 : rdy1;
        end
        if (!got) note_fail("issue_timeout");
        @(posedge clk); #1;
        vld[id] = 1'b0;
        done_cnt++;
    endtask

    task automatic wait_done(input int target, input bit rnd);
        int k = 0;
        while (done_cnt < target && k < 5000) begin
            @(posedge clk); #1;
            if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
            k++;
        end
        if (done_cnt < target) note_fail("wait_done_timeout");
        rsp_ready = 1'b1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = !busy && (sbq.size() == 0) && !rsp_valid;
        end
        if (!ok) note_fail("idle_timeout");
        @(posedge clk); #1;
    endtask

    task automatic rand_req(input int id);
        for (int n = 0; n < N_RAND; n++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            issue(id, 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; rsp_ready = 1'b0;
        vld[0] = 1'b1; op[0] = 1'b0; a[0] = 8'h12; b[0] = 4'h3;
        vld[1] = 1'b1; op[1] = 1'b1; a[1] = 8'h34; b[1] = 4'h5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", 32'(rdy0), 32'd0);
        chk("rst_req1_ready", 32'(rdy1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arr", 32'({arr_z, arr_b, arr_l}), 32'd0);
        chk("rst_rsp_fields", 32'({rsp_id, rsp_dz, rsp_rem, rsp_result}), 32'd0);
        @(posedge clk); #1;
        vld[0] = 1'b0; vld[1] = 1'b0; rst = 1'b0; rsp_ready = 1'b1;

        // Directed multiply, divide and divide-by-zero
        issue(0, 1'b0, 8'h0D, 4'hB);
        wait_idle();
        issue(1, 1'b1, 8'd200, 4'd7);
        wait_idle();
        issue(0, 1'b1, 8'h55, 4'h0);
        @(negedge clk);
        chk("dz_arr", 32'({arr_z, arr_b, arr_l}), 32'd0);
        chk("dz_valid_t1", 32'(rsp_valid), 32'd1);
        wait_idle();

        // Backpressure with a second requester pending
        rsp_ready = 1'b0;
        base = done_cnt;
        fork
            issue(1, 1'b0, 8'h37, 4'h9);
            begin @(posedge clk); #1; issue(0, 1'b1, 8'hC8, 4'h3); end
        join_none
        for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
        if (!rsp_valid) note_fail("bp_no_valid");
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done(base + 2, 1'b0);
        wait_idle();

        // Contention straight out of reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen_ids.delete();
        base = done_cnt;
        fork
            begin issue(0, 1'b0, 8'h12, 4'h5); issue(0, 1'b1, 8'hF0, 4'h4); end
            begin issue(1, 1'b1, 8'h64, 4'hA); issue(1, 1'b0, 8'h0F, 4'hE); end
        join_none
        wait_done(base + 4, 1'b0);
        wait_idle();
        chk("contention_count", 32'(seen_ids.size()), 32'd4);
        for (int k = 0; k < 4 && k < seen_ids.size(); k++)
            chk("contention_order", 32'(seen_ids[k]), 32'(k % 2));

        // Reset during SETTLE aborts the operation
        issue(0, 1'b0, 8'h0F, 4'hF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        base = done_cnt;
        fork
            issue(0, 1'b1, 8'h90, 4'h6);
            issue(1, 1'b0, 8'h03, 4'h3);
        join_none
        @(negedge clk);
        chk("post_rst_grant0", 32'(rdy0), 32'd1);
        chk("post_rst_grant1", 32'(rdy1), 32'd0);
        wait_done(base + 2, 1'b0);
        wait_idle();

        // Randomised traffic from both requesters with random backpressure
        base = done_cnt;
        fork
            rand_req(0);
            rand_req(1);
        join_none
        wait_done(base + 2 * N_RAND, 1'b1);
        wait_idle();

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_array_sched.md
MULDIV_ARRAY_SCHED -- requirements
Module: muldiv_array_sched

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: number of cycles array inputs are held stable before results are captured; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid (N=0,1)  input  1  requester N presents an operation.
REQ-005 reqN_ready  output  1  scheduler accepts requester N's operation this cycle.
REQ-006 reqN_op  input  1  0 = multiply, 1 = divide.
REQ-007 reqN_a  input  8  dividend (divide) or multiplicand in bits [3:0] (multiply).
REQ-008 reqN_b  input  4  divisor (divide) or multiplier (multiply).
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer takes response.
REQ-011 rsp_id  output  1  index of requester that issued the operation.
REQ-012 rsp_result  output  8  product or quotient.
REQ-013 rsp_rem  output  4  remainder; 0 for multiply.
REQ-014 rsp_dz  output  1  divide-by-zero flag.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 arr_l  output  11, arr_b  output  4, arr_z  output  1: drive to the shared combinational array.
REQ-017 arr_mul  input  8, arr_quo  input  8, arr_rem  input  4: results from the array.

Function
REQ-018 The FSM SHALL have states IDLE, SETTLE and DONE.
REQ-019 In IDLE, a grant SHALL be computed combinationally from the valid inputs; only the granted requester sees reqN_ready=1, so at most one ready is high per cycle.
REQ-020 If both requesters are valid in the same cycle, the grant SHALL go to the requester not granted last (round-robin); after reset requester 0 has priority.
REQ-021 On acceptance, op, a, b and id SHALL be registered and drive the array: arr_z=op, arr_b=b, arr_l={3'b000,a} for divide and {7'b0,a[3:0]} for multiply.
REQ-022 arr_l, arr_b and arr_z SHALL remain stable from the cycle after acceptance until the capture cycle inclusive, and SHALL be 0 in IDLE.
REQ-023 After acceptance the FSM SHALL enter SETTLE with a 4-bit down-counter loaded with SETTLE_CYCLES-1, and capture results on the cycle the counter reaches 0.
REQ-024 On capture: multiply yields rsp_result=arr_mul, rsp_rem=0; divide yields rsp_result=arr_quo, rsp_rem=arr_rem. The FSM then enters DONE.
REQ-025 Latency SHALL be: acceptance at cycle T, rsp_valid first high at T+SETTLE_CYCLES+1.
REQ-026 A divide with b=0 SHALL bypass SETTLE and enter DONE at T+1 with rsp_result=8'hFF, rsp_rem=4'h0, rsp_dz=1; rsp_dz SHALL be 0 for all other operations.
REQ-027 In DONE, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be held stable until rsp_valid&rsp_ready.
REQ-028 On rsp_valid&rsp_ready the FSM SHALL return to IDLE; the earliest next acceptance is the following cycle.
REQ-029 No new request SHALL be accepted in SETTLE or DONE; a requester holding valid stays pending.

Reset
REQ-030 On rst, the FSM SHALL enter IDLE, the counter SHALL clear, and the round-robin pointer SHALL favour requester 0. While rst is high, all outputs SHALL be 0.
REQ-031 An rst asserted during SETTLE or DONE SHALL abort the operation and produce no response.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the op encoding constants (OP_MUL=0, OP_DIV=1) and the divide-by-zero result constants.
REQ-033 The round-robin arbiter SHALL be a separate sub-module, rr_arb2, with inputs req[1:0], update and clk/rst, and output gnt[1:0].

Verification
REQ-034 Multiply: req0 op=0, a=8'h0D, b=4'hB -> rsp_result=8'h8F, rsp_rem=0, rsp_id=0, rsp_valid at T+3 (SETTLE_CYCLES=2).
REQ-035 Divide: req1 op=1, a=200, b=7 -> rsp_result=28, rsp_rem=4, rsp_dz=0, rsp_id=1.
REQ-036 Contention: both valid from reset, held high -> order of rsp_id is 0,1,0,1; never two readies high in one cycle.
REQ-037 Divide by zero: a=8'h55, b=0 -> rsp_valid at T+1, rsp_result=8'hFF, rsp_rem=0, rsp_dz=1; arr_* stay 0.
REQ-038 Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable, both reqN_ready=0, busy=1 throughout.
REQ-039 Reset in SETTLE: rst pulsed one cycle after acceptance -> no rsp_valid; busy=0 next cycle; next request granted to requester 0.
